// File: rtl/lfsr_range_pkg.sv
// Shared definitions for the LFSR range generator.
//   t_rg_state   : responder FSM states
//   LFSR_POLY    : default Galois feedback mask (x^32+x^22+x^2+x+1)
//   DIV_CYCLES   : iterations of the shift-subtract modulo
//   lfsr_step()  : one Galois LFSR advance
package lfsr_range_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_STEP  = 3'd2,
    S_DIV   = 3'd3,
    S_RESP  = 3'd4
  } t_rg_state;

  localparam logic [31:0] LFSR_POLY  = 32'h8020_0003;
  localparam int          DIV_CYCLES = 32;

  // Right-shifting Galois form: the bit shifted out selects the feedback XOR.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s, input logic [31:0] poly);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ poly;
    return n;
  endfunction

endpackage

// File: rtl/lfsr_mod_div.sv
// Restoring modulo, one dividend bit per cycle, MSB first.
//   i_clk, i_rst   : clock, synchronous active-high reset (control only)
//   i_start        : load dividend/divisor and begin DIV_CYCLES iterations
//   i_dividend[31:0], i_divisor[32:0] : operands (divisor 1..2^32)
//   o_done         : high during the final iteration cycle
//   o_rem[31:0]    : remainder after the current iteration (final when o_done)
module lfsr_mod_div
  import lfsr_range_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [31:0] i_dividend,
  input  logic [32:0] i_divisor,
  output logic        o_done,
  output logic [31:0] o_rem
);

  logic        r_busy;
  logic [4:0]  r_cnt;
  logic [31:0] r_dvd;
  logic [32:0] r_dvs;
  // Remainder is always below the divisor (<= 2^32), so 32 bits hold it.
  logic [31:0] r_rem;
  logic [32:0] w_shift;
  logic [32:0] w_rem_next;

  assign w_shift    = {r_rem, r_dvd[31]};
  assign w_rem_next = (w_shift >= r_dvs) ? (w_shift - r_dvs) : w_shift;
  assign o_rem      = w_rem_next[31:0];
  assign o_done     = r_busy && (r_cnt == 5'(DIV_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
    end else if (r_busy) begin
      r_cnt <= r_cnt + 5'd1;
      if (o_done) r_busy <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_start) begin
      r_dvd <= i_dividend;
      r_dvs <= i_divisor;
      r_rem <= '0;
    end else if (r_busy) begin
      r_dvd <= {r_dvd[30:0], 1'b0};
      r_rem <= w_rem_next[31:0];
    end
  end

endmodule

// File: rtl/lfsr_range_gen.sv
// Random-number responder for the reaction timer: a 32-bit Galois LFSR,
// seeded on the first accepted request after reset, reduced into the
// inclusive range [lower, upper] by an iterative modulo.
//   i_clk, i_rst           : clock, synchronous active-high reset
//   i_generate             : request, accepted only while o_ready=1
//   i_seed[31:0]           : seed, used only until the first valid request
//   i_upper/i_lower[31:0]  : inclusive bounds, captured at acceptance
//   o_ready                : idle and able to accept
//   o_done                 : one-cycle completion pulse
//   o_invalid              : with o_done, request rejected (o_val=0)
//   o_val[31:0]            : result, held until the next acceptance
// Build option: LFSR_RANGE_GEN_FREE_RUN_EN -- once seeded, the LFSR also
// advances every idle cycle so results depend on request timing.
module lfsr_range_gen
  import lfsr_range_pkg::*;
#(
  parameter logic [31:0] POLY = LFSR_POLY
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_generate,
  input  logic [31:0] i_seed,
  input  logic [31:0] i_upper,
  input  logic [31:0] i_lower,
  output logic        o_ready,
  output logic        o_done,
  output logic        o_invalid,
  output logic [31:0] o_val
);

  t_rg_state   r_state;
  logic        r_seeded;
  logic [31:0] r_lfsr;
  logic [31:0] r_seed;
  logic [31:0] r_upper;
  logic [31:0] r_lower;
  logic [31:0] r_val;
  logic        r_done;
  logic        r_invalid;

  logic        w_accept;
  logic        w_reject;
  logic [31:0] w_lfsr_next;
  logic [32:0] w_range;
  logic        w_div_start;
  logic        w_div_done;
  logic [31:0] w_rem;

  assign w_accept    = (r_state == S_IDLE) && i_generate;
  assign w_reject    = (r_upper < r_lower) || (!r_seeded && (r_seed == 32'd0));
  assign w_lfsr_next = lfsr_step(r_lfsr, POLY);
  // 33 bits so a full 32-bit span (2^32) is representable.
  assign w_range     = {1'b0, r_upper} - {1'b0, r_lower} + 33'd1;
  assign w_div_start = (r_state == S_STEP);

  assign o_ready   = (r_state == S_IDLE);
  assign o_done    = r_done;
  assign o_invalid = r_invalid;
  assign o_val     = r_val;

  // The divider reduces the freshly stepped value, loaded in S_STEP.
  lfsr_mod_div u_div (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (w_div_start),
    .i_dividend (w_lfsr_next),
    .i_divisor  (w_range),
    .o_done     (w_div_done),
    .o_rem      (w_rem)
  );

  // Request operands: frozen at acceptance, seed only while unseeded.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_upper <= i_upper;
      r_lower <= i_lower;
      if (!r_seeded) r_seed <= i_seed;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_seeded  <= 1'b0;
      r_lfsr    <= '0;
      r_val     <= '0;
      r_done    <= 1'b0;
      r_invalid <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_invalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
`ifdef LFSR_RANGE_GEN_FREE_RUN_EN
          if (r_seeded) r_lfsr <= w_lfsr_next;
`endif
          if (w_accept) r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (w_reject) begin
            r_val     <= '0;
            r_done    <= 1'b1;
            r_invalid <= 1'b1;
            r_state   <= S_RESP;
          end else begin
            if (!r_seeded) begin
              r_lfsr   <= r_seed;
              r_seeded <= 1'b1;
            end
            r_state <= S_STEP;
          end
        end
        S_STEP: begin
          r_lfsr  <= w_lfsr_next;
          r_state <= S_DIV;
        end
        S_DIV: begin
          // rem <= upper-lower, so the sum cannot wrap.
          if (w_div_done) begin
            r_val   <= r_lower + w_rem;
            r_done  <= 1'b1;
            r_state <= S_RESP;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_range_gen.sv
module tb_lfsr_range_gen;

  localparam logic [31:0] POLY = 32'h8020_0003;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        gen = 1'b0;
  logic [31:0] seed = '0, upper = '0, lower = '0;
  logic        ready, done, invalid;
  logic [31:0] val;

  lfsr_range_gen dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_generate (gen),
    .i_seed     (seed),
    .i_upper    (upper),
    .i_lower    (lower),
    .o_ready    (ready),
    .o_done     (done),
    .o_invalid  (invalid),
    .o_val      (val)
  );

  always #5 clk = ~clk;

  int ec = 0;
  always @(posedge clk) ec <= ec + 1;

  typedef struct {
    logic [31:0] val;
    logic        inv;
    int          due;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic        m_seeded = 1'b0;
  logic [31:0] m_lfsr = '0;
  int          free_at = 0;

  function automatic logic [31:0] model_step(input logic [31:0] s);
    if (s % 2 == 1) return (s / 2) ^ POLY;
    return s / 2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, req, ec);
    end
  endtask

  // Computes the expected response of a request accepted at the end of cycle n.
  task automatic model_req(input logic [31:0] sd, input logic [31:0] lo,
                           input logic [31:0] up, input int n);
    exp_t e;
    longint unsigned rng;
`ifdef LFSR_RANGE_GEN_FREE_RUN_EN
    if (m_seeded) repeat (n - free_at + 1) m_lfsr = model_step(m_lfsr);
`endif
    if (up < lo || (!m_seeded && sd == 0)) begin
      e.val = 0;
      e.inv = 1'b1;
      e.due = n + 2;
    end else begin
      if (!m_seeded) begin
        m_lfsr   = sd;
        m_seeded = 1'b1;
      end
      m_lfsr = model_step(m_lfsr);
      rng    = longint'(up) - longint'(lo) + 1;
      e.val  = lo + 32'(longint'(m_lfsr) % rng);
      e.inv  = 1'b0;
      e.due  = n + 35;
    end
    q.push_back(e);
    free_at = e.due + 1;
  endtask

  // Called on a negedge; waits gap idle cycles beyond the model's ready point.
  task automatic issue(input logic [31:0] sd, input logic [31:0] lo,
                       input logic [31:0] up, input int gap);
    while (ec < free_at + gap) @(negedge clk);
    check("ready_before_accept", 32'(ready), 32'd1);
    seed  = sd;
    lower = lo;
    upper = up;
    gen   = 1'b1;
    model_req(sd, lo, up, ec);
    @(negedge clk);
    gen   = 1'b0;
    check("ready_after_accept", 32'(ready), 32'd0);
    // Changing inputs after acceptance must not disturb the request.
    seed  = $urandom;
    lower = $urandom;
    upper = $urandom;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    gen = 1'b0;
    repeat (n) @(negedge clk);
    rst      = 1'b0;
    q.delete();
    m_seeded = 1'b0;
    m_lfsr   = '0;
    free_at  = ec;
  endtask

  // Monitor: pops the scoreboard whenever the DUT signals completion.
  always @(negedge clk) begin
    if (!rst) begin
      if (q.size() > 0 && q[0].due < ec) begin
        checks++;
        failures++;
        $display("FAIL missing_done: no o_done by cycle %0d, required at %0d", ec, q[0].due);
        void'(q.pop_front());
      end
      if (invalid && !done) check("invalid_without_done", 32'(invalid), 32'd0);
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: o_done=1 at cycle %0d with nothing outstanding", ec);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("done_cycle", 32'(ec), 32'(e.due));
          check("o_val", val, e.val);
          check("o_invalid", 32'(invalid), 32'(e.inv));
          check("ready_low_at_done", 32'(ready), 32'd0);
        end
      end
    end
  end

  initial begin
    int cnt;
    logic [31:0] lo, up;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_done", 32'(done), 32'd0);
    check("reset_invalid", 32'(invalid), 32'd0);
    check("reset_val", val, 32'd0);
    do_reset(0);

    // Full range: first value is the raw stepped LFSR.
    issue(32'd1, 32'd0, 32'hFFFF_FFFF, 0);

    // Bounded range, then a new seed that must be ignored.
    while (ec < free_at) @(negedge clk);
    do_reset(2);
    issue(32'd1, 32'd2000, 32'd15000, 0);
    issue(32'd5, 32'd2000, 32'd15000, 0);

    // Degenerate range, inverted bounds, then continuation.
    issue(32'd3, 32'd7, 32'd7, 1);
    issue(32'd3, 32'd9, 32'd3, 0);
    issue(32'd3, 32'd0, 32'd100, 2);

    // Zero seed rejected; next request seeds normally.
    while (ec < free_at) @(negedge clk);
    do_reset(2);
    issue(32'd0, 32'd0, 32'hFFFF_FFFF, 0);
    issue(32'd1, 32'd0, 32'hFFFF_FFFF, 0);

    // Request held high: one acceptance per completed request.
    while (ec < free_at) @(negedge clk);
    seed  = 32'd9;
    lower = 32'd100;
    upper = 32'd200;
    gen   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      while (ec < free_at) @(negedge clk);
      check("held_ready", 32'(ready), 32'd1);
      model_req(seed, lower, upper, ec);
      @(negedge clk);
    end
    gen = 1'b0;

    // Reset in the middle of the modulo aborts the request.
    issue(32'd1, 32'd0, 32'hFFFF_FFFF, 0);
    repeat (8) @(negedge clk);
    do_reset(2);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("no_done_after_abort", 32'(cnt), 32'd0);
    issue(32'd1, 32'd0, 32'hFFFF_FFFF, 0);
    issue(32'd1, 32'd0, 32'hFFFF_FFFF, 3);
    issue(32'd1, 32'd0, 32'hFFFF_FFFF, 9);

    // Randomized requests with varied bounds and idle gaps.
    for (int k = 0; k < 24; k++) begin
      lo = $urandom;
      up = $urandom;
      case ($urandom_range(0, 3))
        0: up = lo + 32'($urandom_range(0, 20));
        1: begin lo = 0; up = $urandom; end
        2: if (up > lo) {lo, up} = {up, lo};
        default: ;
      endcase
      if (up == lo && k % 5 == 0) up = lo - 1;
      issue($urandom, lo, up, $urandom_range(0, 5));
    end

    cnt = 0;
    while (q.size() > 0 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", q.size());
    end
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_range_gen.md
# lfsr_range_gen

- Responder for the generate/ready/done/invalid random-number handshake used by the reaction timer.
- Holds a 32-bit Galois LFSR, seeded on the first accepted request after reset, and advances it once per request.
- Reduces the LFSR state into the inclusive range [lower, upper] with an iterative shift-subtract modulo.
- Sits beside the timer FSM as its only source of randomised wait times.

## Interface
- POLY, 32'h8020_0003, Galois feedback mask (x^32+x^22+x^2+x+1).
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_generate  in  1  request; accepted only in a cycle where o_ready=1.
- i_seed  in  32  LFSR seed; sampled only on the first accepted request after reset.
- i_upper  in  32  inclusive upper bound; sampled at acceptance.
- i_lower  in  32  inclusive lower bound; sampled at acceptance.
- o_ready  out  1  high only in S_IDLE.
- o_done  out  1  one-cycle pulse marking a completed request, valid or invalid.
- o_invalid  out  1  one-cycle pulse, coincident with o_done, for a rejected request.
- o_val  out  32  result; held from the o_done cycle until the next acceptance.

## Operation
- Reset values: S_IDLE, seeded=0, LFSR=0, o_val=0, o_done=0, o_invalid=0, o_ready=1.
- States and transitions:
  - S_IDLE: on accept go to S_CHECK.
  - S_CHECK: checks the request, then goes to S_STEP or S_RESP.
  - S_STEP: go to S_DIV.
  - S_DIV: 32 cycles, then go to S_RESP.
  - S_RESP: one cycle, then back to S_IDLE.
- Acceptance (S_IDLE && i_generate) registers upper, lower and, if seeded=0, the seed candidate.
- S_CHECK flags the request invalid when upper<lower, or when seeded=0 and the seed is 0.
  - Invalid: go to S_RESP with o_invalid=1 and o_val=0; the LFSR and the seeded flag are unchanged.
  - Valid: if seeded=0, load LFSR=seed and set seeded=1, then go to S_STEP.
- S_STEP advances the LFSR once (lsb=s[0]; s=s>>1; if lsb then s^=POLY) and computes range=upper-lower+1 as a 33-bit value (range 2^32 is legal).
- S_DIV runs a restoring modulo, MSB first.
  - 33-bit remainder rem, starting at 0.
  - Each cycle: rem=(rem<<1)|bit; if rem>=range then rem-=range.
- S_RESP: o_done=1; o_val=lower+rem[31:0] (cannot overflow, since rem<=upper-lower).
- i_generate while o_ready=0 is ignored; it is neither queued nor does it alter state.
- Input changes after acceptance have no effect on the request in flight.
- Reset in any state aborts the request: no o_done is produced and the seeded flag is cleared.

## Timing
- Acceptance edge is cycle N.
- Valid request: S_CHECK in N+1, S_STEP in N+2, S_DIV in N+3..N+34, o_done=1 in cycle N+35 only.
- Invalid request: o_done=o_invalid=1 in cycle N+2 only.
- o_ready=0 from N+1 through the S_RESP cycle, and is 1 again the cycle after.
- Back-to-back throughput: one valid result per 36 cycles.
- o_done and o_invalid are registered, not combinational from the inputs.

## Configuration
- LFSR_RANGE_GEN_FREE_RUN_EN defined:
  - Once seeded=1, the LFSR also advances every cycle spent in S_IDLE.
  - Results then depend on request timing, giving user-timing entropy.
- Undefined:
  - The LFSR advances only in S_STEP.
  - The output sequence is a pure function of seed and request count.
- The handshake, latency and invalid rules are identical in both builds.

## Structure
- Shared package lfsr_range_pkg holds:
  - the state enum t_rg_state;
  - the default POLY constant;
  - DIV_CYCLES=32;
  - a function lfsr_step(s, poly).
- Optional sub-module lfsr_mod_div containing the S_DIV datapath, with start/done and a 32-bit dividend and 33-bit divisor. Everything else stays in one FSM.

## Test plan
- Reset, then seed=1, lower=0, upper=32'hFFFF_FFFF, generate at N -> o_done in N+35, o_val=32'h8020_0003, o_invalid=0.
- After reset, seed=1, lower=2000, upper=15000 -> o_val=10464. A second request with seed=5 must ignore the new seed and continue the sequence.
- lower=upper=7 -> o_val=7. lower=9, upper=3 -> o_done=o_invalid=1 in N+2, o_val=0, and the next valid request gives the unchanged next LFSR value.
- First request with seed=0 -> invalid and seeded stays 0. A following request with seed=1 -> o_val=32'h8020_0003 (full range).
- i_generate held high throughout -> exactly one accept per 36 cycles, and o_done never asserts with o_ready=1.
- i_rst asserted at N+10 mid-S_DIV -> no o_done. Next request with seed=1 (full range) -> 32'h8020_0003. With LFSR_RANGE_GEN_FREE_RUN_EN defined, two idle-gap lengths give differing second results.
